// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shifter state encoding and default widths
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shifter_right_seq_if.sv
// rtl/shifter_right_seq_if.sv - operand/result handshake bundle for the right shifter
interface shifter_right_seq_if #(
    parameter int WIDTH = shift_pkg::DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [CNT_W-1:0] amt;
    logic             arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_s;
    logic             shifted_out;

    // Producer/consumer side
    modport master (
        output in_valid, a, amt, arith, out_ready,
        input  in_ready, out_valid, a_s, shifted_out
    );

    // Shifter side
    modport slave (
        input  in_valid, a, amt, arith, out_ready,
        output in_ready, out_valid, a_s, shifted_out
    );
endinterface

// File: rtl/shifter_right_step.sv
// rtl/shifter_right_step.sv - combinational one-bit right shift, logical or arithmetic
module shifter_right_step #(
    parameter int WIDTH = shift_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic             arith,
    output logic [WIDTH-1:0] a_s,
    output logic             shifted_out
);
    // Sign bit is replicated only for arithmetic shifts
    logic fill;
    assign fill        = arith & a[WIDTH-1];
    assign a_s         = {fill, a[WIDTH-1:1]};
    assign shifted_out = a[0];
endmodule

// File: rtl/shifter_right_seq.sv
// rtl/shifter_right_seq.sv - sequential right shifter, one bit per clock
module shifter_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    shifter_right_seq_if.slave  bus
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] work;
    logic             arith_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_s_q;
    logic             shifted_out_q;

    logic [CNT_W-1:0] k;
    logic [WIDTH-1:0] step_a_s;
    logic             step_out;

    // Distances beyond the operand width saturate: the result is already fully filled
    assign k = (bus.amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.amt;

    shifter_right_step #(.WIDTH(WIDTH)) u_step (
        .a           (work),
        .arith       (arith_q),
        .a_s         (step_a_s),
        .shifted_out (step_out)
    );

    // Control FSM, countdown and registered datapath/outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            work          <= '0;
            arith_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            a_s_q         <= '0;
            shifted_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work       <= bus.a;
                        arith_q    <= bus.arith;
                        in_ready_q <= 1'b0;
                        if (k == '0) begin
                            a_s_q         <= bus.a;
                            shifted_out_q <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            cnt   <= k;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work          <= step_a_s;
                    shifted_out_q <= step_out;
                    cnt           <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        a_s_q       <= step_a_s;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.a_s         = a_s_q;
    assign bus.shifted_out = shifted_out_q;
endmodule

// File: tb/tb_shifter_right_seq.sv
// tb/tb_shifter_right_seq.sv - randomized self-checking bench for shifter_right_seq
module tb_shifter_right_seq;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    shifter_right_seq_if #(.WIDTH(W)) bus ();

    shifter_right_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: right shift by min(amt, W), sign or zero fill; last bit out is a[k-1]
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input int amt, input logic arith);
        int k;
        logic signed [W-1:0] sa;
        k  = (amt > W) ? W : amt;
        sa = a;
        if (arith) return W'(sa >>> k);
        return a >> k;
    endfunction

    function automatic logic ref_out(input logic [W-1:0] a, input int amt);
        int k;
        k = (amt > W) ? W : amt;
        if (k == 0) return 1'b0;
        return a[k-1];
    endfunction

    task automatic do_op(input logic [W-1:0] a, input int amt, input logic arith, input int hold);
        int k;
        int n;
        logic [W-1:0] exp_a;
        logic         exp_o;
        k     = (amt > W) ? W : amt;
        exp_a = ref_res(a, amt, arith);
        exp_o = ref_out(a, amt);
        @(negedge clk);
        check_eq("in_ready_idle", 8'(bus.in_ready), 8'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.amt       = 3'(amt);
        bus.arith     = arith;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 4'($urandom);
        bus.amt      = 3'($urandom);
        bus.arith    = 1'($urandom);
        check_eq("in_ready_fall", 8'(bus.in_ready), 8'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", 8'(n), 8'(k));
        check_eq("a_s", 8'(bus.a_s), 8'(exp_a));
        check_eq("shifted_out", 8'(bus.shifted_out), 8'(exp_o));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                @(posedge clk);
                #1;
                check_eq("bp_valid", 8'(bus.out_valid), 8'd1);
                check_eq("bp_a_s", 8'(bus.a_s), 8'(exp_a));
                check_eq("bp_out", 8'(bus.shifted_out), 8'(exp_o));
                check_eq("bp_in_ready", 8'(bus.in_ready), 8'd0);
            end
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("valid_drop", 8'(bus.out_valid), 8'd0);
        check_eq("in_ready_rise", 8'(bus.in_ready), 8'd1);
    endtask

    initial begin
        int seen;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.amt       = '0;
        bus.arith     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 8'(bus.in_ready), 8'd1);
        check_eq("rst_out_valid", 8'(bus.out_valid), 8'd0);
        check_eq("rst_a_s", 8'(bus.a_s), 8'd0);
        check_eq("rst_shifted_out", 8'(bus.shifted_out), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        do_op(4'b1011, 1, 1'b0, 0);
        do_op(4'b1011, 2, 1'b1, 0);
        do_op(4'b1011, 2, 1'b0, 0);
        do_op(4'b0110, 0, 1'b0, 0);
        do_op(4'b1001, 7, 1'b0, 0);
        do_op(4'b1001, 7, 1'b1, 0);
        do_op(4'b1101, 3, 1'b1, 3);

        // Reset while shifting aborts the operation without a result
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 4'b1000;
        bus.amt      = 3'd3;
        bus.arith    = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_out_valid", 8'(bus.out_valid), 8'd0);
        check_eq("abort_a_s", 8'(bus.a_s), 8'd0);
        check_eq("abort_shifted_out", 8'(bus.shifted_out), 8'd0);
        check_eq("abort_in_ready", 8'(bus.in_ready), 8'd1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_eq("abort_no_result", 8'(seen), 8'd0);
        do_op(4'b1000, 3, 1'b1, 0);

        // Exhaustive sweep of operand, distance and mode
        for (int av = 0; av < 16; av++)
            for (int am = 0; am < 8; am++)
                for (int ar = 0; ar < 2; ar++)
                    do_op(4'(av), am, 1'(ar), 0);

        // Random operations with random backpressure
        repeat (60) do_op(4'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                          int'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
